i2c_target_regfile: RTL and testbench

- Parametrised I2C target (slave) owning a bank of REG_COUNT byte registers, exposed in parallel to downstream output logic.
- Adds to the previous fixed-size design: configurable register count, pin-strapped device address bits, pointer auto-increment with wrap, a read-only status window fed from parallel_in, and NACK of out-of-range pointers.
- Sits between the chip pads (SCL/SDA) and the output-mapping logic.

---
 rtl/i2c_pkg.sv | 34 +++
 rtl/i2c_bus_cond.sv | 52 +++++
 rtl/i2c_target_regfile.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_pkg : shared state encoding, ACK levels and address helper           |
// | Revision: 1.1                                                            |
// +--------------------------------------------------------------------------+
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RACK,
    S_WAIT_STOP
  } i2c_state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Low sel_w bits of the base address are replaced by the strap pins.
  function automatic logic [6:0] match_addr(input logic [6:0] dev_addr,
                                            input logic [2:0] sel,
                                            input int         sel_w);
    logic [6:0] mask;
    mask = 7'((8'd1 << sel_w) - 8'd1);
    return (dev_addr & ~mask) | ({4'b0000, sel} & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_bus_cond.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_bus_cond : SCL/SDA synchronisers, edge detect, START/STOP pulses     |
// | Revision: 1.1                                                            |
// +--------------------------------------------------------------------------+
module i2c_bus_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  assign sda      = w_sda;
  assign scl_rise = w_scl & ~r_scl_d;
  assign scl_fall = ~w_scl & r_scl_d;
  // SCL must be stable high across the SDA edge for a bus condition.
  assign start    = w_scl & r_scl_d & ~w_sda & r_sda_d;
  assign stop     = w_scl & r_scl_d & w_sda & ~r_sda_d;

endmodule
`default_nettype wire

// File: rtl/i2c_target_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_target_regfile : I2C target with pointer-addressed byte register bank|
// | Revision: 1.1                                                            |
// +--------------------------------------------------------------------------+
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter int         REG_COUNT   = 28,
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         ADDR_SEL_W  = 2,
  parameter int         RO_COUNT    = 1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         scl_in,
  input  logic                         sda_in,
  input  logic [ADDR_SEL_W-1:0]        addr_sel,
  input  logic [7:0]                   parallel_in,
  output logic                         sda_pull,
  output logic [8*REG_COUNT-1:0]       registers_packed,
  output logic                         wr_strobe,
  output logic [$clog2(REG_COUNT)-1:0] wr_index,
  output logic                         busy
);

  localparam int c_PW      = $clog2(REG_COUNT);
  localparam int c_RO_BASE = REG_COUNT - RO_COUNT;

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_bus_cond #(.SYNC_STAGES(SYNC_STAGES)) u_bus_cond (
    .clock    (clock),
    .reset    (reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda      (w_sda),
    .scl_rise (w_scl_rise),
    .scl_fall (w_scl_fall),
    .start    (w_start),
    .stop     (w_stop)
  );

  i2c_state_t            r_state, n_state;
  logic [3:0]            r_cnt, n_cnt;
  logic [7:0]            r_shift, n_shift;
  logic [c_PW-1:0]       r_ptr, n_ptr;
  logic                  r_pull, n_pull;
  logic                  r_rw, n_rw;
  logic                  r_busy, n_busy;
  logic                  r_wr_strobe, n_wr_strobe;
  logic [c_PW-1:0]       r_wr_index, n_wr_index;
  logic [ADDR_SEL_W-1:0] r_addr_sel;
  logic [7:0]            r_regs [REG_COUNT];

  logic            w_we;
  logic [7:0]      w_byte;
  logic [7:0]      w_rd_byte;
  logic            w_ro;
  logic [c_PW-1:0] w_ptr_inc;
  logic [6:0]      w_dev_addr;

  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_ro       = int'(r_ptr) >= c_RO_BASE;
  assign w_rd_byte  = w_ro ? parallel_in : r_regs[r_ptr];
  assign w_ptr_inc  = (int'(r_ptr) == REG_COUNT - 1) ? '0 : r_ptr + c_PW'(1);
  assign w_dev_addr = match_addr(DEV_ADDR, 3'(r_addr_sel), ADDR_SEL_W);

  always_comb begin
    n_state     = r_state;
    n_cnt       = r_cnt;
    n_shift     = r_shift;
    n_ptr       = r_ptr;
    n_pull      = r_pull;
    n_rw        = r_rw;
    n_busy      = r_busy;
    n_wr_strobe = 1'b0;
    n_wr_index  = r_wr_index;
    w_we        = 1'b0;
    if (w_start) begin
      n_state = S_ADDR;
      n_cnt   = '0;
      n_pull  = 1'b0;
      n_busy  = 1'b1;
    end else if (w_stop) begin
      n_state = S_IDLE;
      n_pull  = 1'b0;
      n_busy  = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_PTR, S_WDATA: begin
          if (w_scl_rise) begin
            n_shift = w_byte;
            n_cnt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              n_cnt = '0;
              case (r_state)
                S_ADDR: begin
                  if (w_byte[7:1] == w_dev_addr) begin
                    n_state = S_ADDR_ACK;
                    n_rw    = w_byte[0];
                  end else begin
                    n_state = S_WAIT_STOP;
                  end
                end
                S_PTR: begin
                  if (w_byte < 8'(REG_COUNT)) begin
                    n_ptr   = w_byte[c_PW-1:0];
                    n_state = S_PTR_ACK;
                  end else begin
                    n_state = S_WAIT_STOP;
                  end
                end
                default: begin
                  if (!w_ro) begin
                    w_we        = 1'b1;
                    n_wr_strobe = 1'b1;
                    n_wr_index  = r_ptr;
                  end
                  n_ptr   = w_ptr_inc;
                  n_state = S_WDATA_ACK;
                end
              endcase
            end
          end
        end
        // r_cnt marks whether the ACK slot has started (0) or is ending (1).
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (w_scl_fall) begin
            if (r_cnt == 4'd0) begin
              n_pull = ~ACK;
              n_cnt  = 4'd1;
            end else begin
              n_pull = 1'b0;
              n_cnt  = '0;
              if (r_state == S_ADDR_ACK && r_rw) begin
                n_shift = w_rd_byte;
                n_pull  = ~w_rd_byte[7];
                n_state = S_RDATA;
              end else if (r_state == S_ADDR_ACK) begin
                n_state = S_PTR;
              end else begin
                n_state = S_WDATA;
              end
            end
          end
        end
        S_RDATA: begin
          if (w_scl_rise) begin
            n_cnt = r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              n_pull  = 1'b0;
              n_cnt   = '0;
              n_state = S_RACK;
            end else begin
              n_shift = {r_shift[6:0], r_shift[7]};
              n_pull  = ~r_shift[6];
            end
          end
        end
        S_RACK: begin
          if (w_scl_rise) begin
            if (w_sda == NACK) begin
              n_state = S_WAIT_STOP;
            end else begin
              n_ptr = w_ptr_inc;
              n_cnt = 4'd1;
            end
          end else if (w_scl_fall && r_cnt == 4'd1) begin
            n_shift = w_rd_byte;
            n_pull  = ~w_rd_byte[7];
            n_cnt   = '0;
            n_state = S_RDATA;
          end
        end
        default: begin
          n_pull = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_pull      <= 1'b0;
      r_rw        <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_index  <= '0;
      r_addr_sel  <= '0;
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else begin
      r_state     <= n_state;
      r_cnt       <= n_cnt;
      r_shift     <= n_shift;
      r_ptr       <= n_ptr;
      r_pull      <= n_pull;
      r_rw        <= n_rw;
      r_busy      <= n_busy;
      r_wr_strobe <= n_wr_strobe;
      r_wr_index  <= n_wr_index;
      if (w_start) r_addr_sel <= addr_sel;
      if (w_we) r_regs[r_ptr] <= w_byte;
    end
  end

  // Read-only slots are never written, so they pack out as zero.
  for (genvar i = 0; i < REG_COUNT; i++) begin : g_pack
    assign registers_packed[8*i +: 8] = r_regs[i];
  end

  assign sda_pull  = r_pull;
  assign wr_strobe = r_wr_strobe;
  assign wr_index  = r_wr_index;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2c_target_regfile : directed bus-master bench for the register file  |
// | Revision: 1.1                                                            |
// +--------------------------------------------------------------------------+
module tb_i2c_target_regfile;

  localparam int REG_COUNT = 28;
  localparam int PW        = 5;
  localparam int Q         = 100;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   scl = 1'b1;
  logic                   m_sda = 1'b1;
  logic [1:0]             addr_sel = 2'b01;
  logic [7:0]             parallel_in = 8'h7E;
  logic                   sda_pull;
  logic [8*REG_COUNT-1:0] registers_packed;
  logic                   wr_strobe;
  logic [PW-1:0]          wr_index;
  logic                   busy;
  logic                   sda_line;

  logic [8*REG_COUNT-1:0] exp_regs = '0;
  int                     checks = 0;
  int                     failures = 0;
  int                     strobe_cnt = 0;
  int                     pull_cycles = 0;
  logic [PW-1:0]          idx_log [16];

  assign sda_line = m_sda & ~sda_pull;

  i2c_target_regfile dut (
    .clock            (clk),
    .reset            (rst_n),
    .scl_in           (scl),
    .sda_in           (sda_line),
    .addr_sel         (addr_sel),
    .parallel_in      (parallel_in),
    .sda_pull         (sda_pull),
    .registers_packed (registers_packed),
    .wr_strobe        (wr_strobe),
    .wr_index         (wr_index),
    .busy             (busy)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_strobe) begin
      idx_log[strobe_cnt % 16] <= wr_index;
      strobe_cnt <= strobe_cnt + 1;
    end
    if (sda_pull) pull_cycles <= pull_cycles + 1;
  end

  task automatic i2c_start();
    m_sda = 1'b1; #Q;
    scl = 1'b1;   #Q;
    m_sda = 1'b0; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #Q;
    scl = 1'b1;   #Q;
    m_sda = 1'b1; #Q;
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; #Q;
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; #Q;
    scl = 1'b1;   #Q;
    ack = sda_line; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl = 1'b1;
      #Q; d[i] = sda_line;
      #Q; scl = 1'b0;
      #Q;
    end
    m_sda = ack_bit; #Q;
    scl = 1'b1;      #(2*Q);
    scl = 1'b0;      #Q;
    m_sda = 1'b1;
  endtask

  task automatic test_reset();
    #203 rst_n = 1'b1;
    #200;
    checks++; if (sda_pull !== 1'b0) begin failures++; $display("FAIL reset_sda_pull got %0b want 0", sda_pull); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (wr_strobe !== 1'b0 || wr_index !== '0) begin failures++; $display("FAIL reset_wr got strobe=%0b idx=%0d want 0/0", wr_strobe, wr_index); end
    checks++; if (registers_packed !== '0) begin failures++; $display("FAIL reset_regs got %h want 0", registers_packed); end
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3;
    int   s0;
    s0 = strobe_cnt;
    i2c_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL write_busy got %0b want 1", busy); end
    write_byte(8'hA2, a0);
    write_byte(8'h03, a1);
    write_byte(8'h5A, a2);
    write_byte(8'hC3, a3);
    i2c_stop();
    #Q;
    exp_regs[31:24] = 8'h5A;
    exp_regs[39:32] = 8'hC3;
    checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin failures++; $display("FAIL write_acks got %b want 0000", {a0, a1, a2, a3}); end
    checks++; if (registers_packed !== exp_regs) begin failures++; $display("FAIL write_regs got %h want %h", registers_packed, exp_regs); end
    checks++; if (strobe_cnt - s0 != 2) begin failures++; $display("FAIL write_strobes got %0d want 2", strobe_cnt - s0); end
    checks++; if (idx_log[s0 % 16] !== 5'd3 || idx_log[(s0 + 1) % 16] !== 5'd4) begin
      failures++; $display("FAIL write_index got %0d,%0d want 3,4", idx_log[s0 % 16], idx_log[(s0 + 1) % 16]);
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL write_busy_after_stop got %0b want 0", busy); end
  endtask

  task automatic test_read_wrap();
    logic       a;
    logic [7:0] d0, d1, d2;
    i2c_start(); write_byte(8'hA2, a); write_byte(8'h1A, a); write_byte(8'h3C, a); i2c_stop();
    i2c_start(); write_byte(8'hA2, a); write_byte(8'h00, a); write_byte(8'h81, a); i2c_stop();
    exp_regs[215:208] = 8'h3C;
    exp_regs[7:0]     = 8'h81;
    i2c_start();
    write_byte(8'hA2, a);
    write_byte(8'h1A, a);
    i2c_start();
    write_byte(8'hA3, a);
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL read_addr_ack got %0b want 0", a); end
    read_byte(1'b0, d0);
    read_byte(1'b0, d1);
    read_byte(1'b1, d2);
    checks++; if (d0 !== 8'h3C) begin failures++; $display("FAIL read_reg26 got %h want 3c", d0); end
    checks++; if (d1 !== 8'h7E) begin failures++; $display("FAIL read_ro27 got %h want 7e", d1); end
    checks++; if (d2 !== 8'h81) begin failures++; $display("FAIL read_wrap_reg0 got %h want 81", d2); end
    #Q;
    checks++; if (sda_pull !== 1'b0) begin failures++; $display("FAIL read_release got %0b want 0", sda_pull); end
    i2c_stop();
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    int   p0, s0;
    p0 = pull_cycles;
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h00, a1);
    i2c_stop();
    #Q;
    checks++; if ({a0, a1} !== 2'b11) begin failures++; $display("FAIL mismatch_acks got %b want 11", {a0, a1}); end
    checks++; if (pull_cycles != p0) begin failures++; $display("FAIL mismatch_pull got %0d cycles want 0", pull_cycles - p0); end
    checks++; if (registers_packed !== exp_regs || strobe_cnt != s0) begin
      failures++; $display("FAIL mismatch_regs got %h want %h", registers_packed, exp_regs);
    end
  endtask

  task automatic test_ptr_range();
    logic a0, a1, a2;
    int   s0;
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'hA2, a0);
    write_byte(8'h1C, a1);
    write_byte(8'h77, a2);
    i2c_stop();
    #Q;
    checks++; if ({a0, a1} !== 2'b01) begin failures++; $display("FAIL ptr_range_ack got %b want 01", {a0, a1}); end
    checks++; if (a2 !== 1'b1) begin failures++; $display("FAIL ptr_range_data_ack got %0b want 1", a2); end
    checks++; if (strobe_cnt != s0 || registers_packed !== exp_regs) begin
      failures++; $display("FAIL ptr_range_nowrite got strobes=%0d regs=%h want 0 %h", strobe_cnt - s0, registers_packed, exp_regs);
    end
  endtask

  task automatic test_ro_write();
    logic a0, a1, a2;
    int   s0;
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'hA2, a0);
    write_byte(8'h1B, a1);
    write_byte(8'hFF, a2);
    i2c_stop();
    #Q;
    checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL ro_acks got %b want 000", {a0, a1, a2}); end
    checks++; if (strobe_cnt != s0) begin failures++; $display("FAIL ro_strobe got %0d want 0", strobe_cnt - s0); end
    checks++; if (registers_packed[223:216] !== 8'h00) begin failures++; $display("FAIL ro_reg27 got %h want 00", registers_packed[223:216]); end
  endtask

  task automatic test_reset_midxfer();
    logic a;
    int   s0;
    i2c_start();
    write_byte(8'hA2, a);
    write_byte(8'h05, a);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    m_sda = 1'b0; #Q;
    scl = 1'b1; #50;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midxfer_busy_before got %0b want 1", busy); end
    rst_n = 1'b0;
    #1;
    exp_regs = '0;
    checks++; if (sda_pull !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midxfer_reset got pull=%0b busy=%0b want 0/0", sda_pull, busy); end
    checks++; if (registers_packed !== '0) begin failures++; $display("FAIL midxfer_regs got %h want 0", registers_packed); end
    m_sda = 1'b1;
    #Q;
    rst_n = 1'b1;
    #(2*Q);
    s0 = strobe_cnt;
    test_write();
    checks++; if (idx_log[s0 % 16] !== 5'd3) begin failures++; $display("FAIL midxfer_rewrite_idx got %0d want 3", idx_log[s0 % 16]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wrap();
    test_mismatch();
    test_ptr_range();
    test_ro_write();
    test_reset_midxfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
